multicycle_processor: RTL and testbench

//  Parametrised multi-cycle RISC-V integer core: FETCH/DECODE/EXEC/MEM/WB state machine.

---
 rtl/multicycle_processor_if.sv | 24 ++
 rtl/multicycle_processor.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_processor.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_processor_if.sv
// Instruction and data memory handshakes for the multi-cycle core.
// The core owns req/addr/we/wdata; the memories answer with ready/rdata.
interface multicycle_processor_if #(parameter int XLEN = 64);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic [31:0]     imem_rdata;
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_ready;
   logic [XLEN-1:0] dmem_rdata;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  imem_ready, imem_rdata, dmem_ready, dmem_rdata
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output imem_ready, imem_rdata, dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/multicycle_processor.sv
// Multi-cycle RV integer core (add/sub/and/or/addi/load/store/beq) with
// stall-tolerant memory handshakes and a sticky halt on illegal instructions.
module multicycle_processor #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   multicycle_processor_if.master bus,
   output logic                  wb_valid,
   output logic [4:0]            wb_rd,
   output logic [XLEN-1:0]       wb_data,
   output logic [XLEN-1:0]       pc,
   output logic                  halt
);
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
   typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LD, OP_ST, OP_BEQ} op_t;

   localparam logic [2:0]      F3_LS   = (XLEN == 64) ? 3'b011 : 3'b010;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   state_t          state;
   op_t             op, dec_op;
   logic            dec_ok;
   logic [31:0]     ir;
   logic [XLEN-1:0] a, b, imm, dec_imm, alu, br_target, pc_next4;
   logic [XLEN-1:0] rdata1, rdata2;
   logic [XLEN-1:0] imm_i, imm_s, imm_b;
   logic [4:0]      rd;
   logic [XLEN-1:0] regs [32];

   logic            imem_req, dmem_req, dmem_we;
   logic [XLEN-1:0] dmem_addr, dmem_wdata;

   assign bus.imem_req   = imem_req;
   assign bus.imem_addr  = pc;
   assign bus.dmem_req   = dmem_req;
   assign bus.dmem_we    = dmem_we;
   assign bus.dmem_addr  = dmem_addr;
   assign bus.dmem_wdata = dmem_wdata;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;
   logic [4:0] rs1, rs2;
   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];

   assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
   assign imm_s = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
   assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

   assign rdata1 = (rs1 == 5'd0) ? '0 : regs[rs1];
   assign rdata2 = (rs2 == 5'd0) ? '0 : regs[rs2];

   always_comb begin
      dec_ok  = 1'b1;
      dec_op  = OP_ADD;
      dec_imm = imm_i;
      case (opcode)
         7'b0110011: begin
            if (funct3 == 3'b000 && funct7 == 7'b0000000)      dec_op = OP_ADD;
            else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_op = OP_SUB;
            else if (funct3 == 3'b111 && funct7 == 7'b0000000) dec_op = OP_AND;
            else if (funct3 == 3'b110 && funct7 == 7'b0000000) dec_op = OP_OR;
            else                                               dec_ok = 1'b0;
         end
         7'b0010011: if (funct3 == 3'b000) dec_op = OP_ADDI; else dec_ok = 1'b0;
         7'b0000011: if (funct3 == F3_LS)  dec_op = OP_LD;   else dec_ok = 1'b0;
         7'b0100011: begin
            dec_imm = imm_s;
            if (funct3 == F3_LS) dec_op = OP_ST; else dec_ok = 1'b0;
         end
         7'b1100011: begin
            dec_imm = imm_b;
            if (funct3 == 3'b000) dec_op = OP_BEQ; else dec_ok = 1'b0;
         end
         default: dec_ok = 1'b0;
      endcase
   end

   // addi and load/store address share the a+imm path
   always_comb begin
      alu = a + imm;
      case (op)
         OP_ADD:  alu = a + b;
         OP_SUB:  alu = a - b;
         OP_AND:  alu = a & b;
         OP_OR:   alu = a | b;
         default: alu = a + imm;
      endcase
   end

   assign br_target = pc + imm;
   assign pc_next4  = pc + PC_STEP;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         ir         <= '0;
         a          <= '0;
         b          <= '0;
         imm        <= '0;
         op         <= OP_ADD;
         rd         <= '0;
         imem_req   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         wb_valid   <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         halt       <= 1'b0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               // first cycle out of reset only raises the request
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (bus.imem_ready) begin
                  ir       <= bus.imem_rdata;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (!dec_ok) begin
                  halt  <= 1'b1;
                  state <= S_HALT;
               end else begin
                  a     <= rdata1;
                  b     <= rdata2;
                  imm   <= dec_imm;
                  op    <= dec_op;
                  rd    <= ir[11:7];
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               case (op)
                  OP_BEQ: begin
                     if (a == b && br_target[1:0] != 2'b00) begin
                        halt  <= 1'b1;
                        state <= S_HALT;
                     end else begin
                        pc       <= (a == b) ? br_target : pc_next4;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                     end
                  end
                  OP_LD, OP_ST: begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= (op == OP_ST);
                     dmem_addr  <= alu;
                     dmem_wdata <= (op == OP_ST) ? b : '0;
                     state      <= S_MEM;
                  end
                  default: begin
                     wb_valid <= (rd != 5'd0);
                     wb_rd    <= rd;
                     wb_data  <= alu;
                     state    <= S_WB;
                  end
               endcase
            end
            S_MEM: begin
               if (bus.dmem_ready) begin
                  dmem_req <= 1'b0;
                  if (dmem_we) begin
                     dmem_we  <= 1'b0;
                     pc       <= pc_next4;
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end else begin
                     wb_valid <= (rd != 5'd0);
                     wb_rd    <= rd;
                     wb_data  <= bus.dmem_rdata;
                     state    <= S_WB;
                  end
               end
            end
            S_WB: begin
               if (wb_valid) regs[wb_rd] <= wb_data;
               wb_valid <= 1'b0;
               pc       <= pc_next4;
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            S_HALT: ;
            default: state <= S_HALT;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_processor.sv
// Directed bench for multicycle_processor: a program table executed in order,
// then halt/reset and reset-during-MEM sequences.
module tb_multicycle_processor;
   localparam int XLEN = 64;

   logic            clk;
   logic            rst_n;
   logic            wb_valid;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic [XLEN-1:0] pc;
   logic            halt;

   int errors = 0;
   int checks = 0;
   logic [63:0] dmem [16];

   multicycle_processor_if #(.XLEN(XLEN)) bus();

   multicycle_processor #(.XLEN(XLEN), .RESET_PC(64'h0)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .wb_valid (wb_valid),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data),
      .pc       (pc),
      .halt     (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      int          mem_delay;
      logic        exp_wb;
      logic [4:0]  exp_rd;
      logic [63:0] exp_data;
      logic        exp_mem;
      logic        exp_we;
      logic [63:0] exp_maddr;
      logic [63:0] exp_wdata;
      logic [63:0] exp_next;
      int          exp_cycles;
      logic        exp_halt;
   } vec_t;

   function automatic vec_t mk(logic [63:0] p, logic [31:0] ins, int dly,
                               logic w, logic [4:0] r, logic [63:0] d,
                               logic m, logic we, logic [63:0] ma, logic [63:0] wd,
                               logic [63:0] nx, int cy, logic h);
      vec_t v;
      v.pc = p; v.instr = ins; v.mem_delay = dly;
      v.exp_wb = w; v.exp_rd = r; v.exp_data = d;
      v.exp_mem = m; v.exp_we = we; v.exp_maddr = ma; v.exp_wdata = wd;
      v.exp_next = nx; v.exp_cycles = cy; v.exp_halt = h;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_fetch(output bit ok);
      int n = 0;
      while (!bus.imem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = bus.imem_req;
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      bit          ok;
      bit          stable;
      int          cyc;
      logic        got_wb, got_mem;
      logic [4:0]  got_rd;
      logic [63:0] got_data, a0, w0;
      logic        we0;
      wait_fetch(ok);
      chk({tag, "_fetch_req"}, 64'(ok), 64'd1);
      if (!ok) return;
      chk({tag, "_imem_addr"}, bus.imem_addr, v.pc);
      bus.imem_ready = 1'b1;
      bus.imem_rdata = v.instr;
      cyc = 1;
      @(negedge clk);
      bus.imem_ready = 1'b0;
      cyc++;
      got_wb = 1'b0; got_mem = 1'b0; got_rd = '0; got_data = '0;
      while (!bus.imem_req && !halt && cyc < 40) begin
         if (wb_valid) begin
            got_wb = 1'b1; got_rd = wb_rd; got_data = wb_data;
         end
         if (bus.dmem_req && !got_mem) begin
            got_mem = 1'b1;
            a0 = bus.dmem_addr; w0 = bus.dmem_wdata; we0 = bus.dmem_we;
            chk({tag, "_mem_we"}, 64'(we0), 64'(v.exp_we));
            chk({tag, "_mem_addr"}, a0, v.exp_maddr);
            if (v.exp_we) chk({tag, "_mem_wdata"}, w0, v.exp_wdata);
            stable = 1'b1;
            for (int d = 0; d < v.mem_delay; d++) begin
               @(negedge clk);
               cyc++;
               if (!bus.dmem_req || bus.dmem_addr !== a0 || bus.dmem_wdata !== w0 || bus.dmem_we !== we0)
                  stable = 1'b0;
            end
            if (v.mem_delay > 0) chk({tag, "_mem_hold"}, 64'(stable), 64'd1);
            bus.dmem_ready = 1'b1;
            bus.dmem_rdata = dmem[a0[6:3]];
            if (we0) dmem[a0[6:3]] = w0;
         end
         @(negedge clk);
         bus.dmem_ready = 1'b0;
         cyc++;
      end
      chk({tag, "_done"}, 64'(bus.imem_req || halt), 64'd1);
      chk({tag, "_cycles"}, 64'(cyc - 1), 64'(v.exp_cycles));
      chk({tag, "_mem_seen"}, 64'(got_mem), 64'(v.exp_mem));
      chk({tag, "_wb_valid"}, 64'(got_wb), 64'(v.exp_wb));
      if (v.exp_wb) begin
         chk({tag, "_wb_rd"}, 64'(got_rd), 64'(v.exp_rd));
         chk({tag, "_wb_data"}, got_data, v.exp_data);
      end
      chk({tag, "_halt"}, 64'(halt), 64'(v.exp_halt));
      if (!v.exp_halt) chk({tag, "_next_pc"}, bus.imem_addr, v.exp_next);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t prog[14];
      bit   ok;
      bit   sticky;
      int   n;

      //             pc     instr         dly wb rd data                    mem we addr   wdata  next   cyc halt
      prog[0]  = mk(64'h00, 32'h00500093, 0, 1, 1, 64'd5,                   0, 0, 64'd0, 64'd0,  64'h04, 4, 0);
      prog[1]  = mk(64'h04, 32'h00108133, 0, 1, 2, 64'd10,                  0, 0, 64'd0, 64'd0,  64'h08, 4, 0);
      prog[2]  = mk(64'h08, 32'h00203423, 3, 0, 0, 64'd0,                   1, 1, 64'd8, 64'd10, 64'h0C, 7, 0);
      prog[3]  = mk(64'h0C, 32'h00803183, 3, 1, 3, 64'd10,                  1, 0, 64'd8, 64'd0,  64'h10, 8, 0);
      prog[4]  = mk(64'h10, 32'h00208463, 0, 0, 0, 64'd0,                   0, 0, 64'd0, 64'd0,  64'h14, 3, 0);
      prog[5]  = mk(64'h14, 32'h00108463, 0, 0, 0, 64'd0,                   0, 0, 64'd0, 64'd0,  64'h1C, 3, 0);
      prog[6]  = mk(64'h1C, 32'h40100233, 0, 1, 4, 64'hFFFF_FFFF_FFFF_FFFB, 0, 0, 64'd0, 64'd0,  64'h20, 4, 0);
      prog[7]  = mk(64'h20, 32'h00100013, 0, 0, 0, 64'd0,                   0, 0, 64'd0, 64'd0,  64'h24, 4, 0);
      prog[8]  = mk(64'h24, 32'h000002B3, 0, 1, 5, 64'd0,                   0, 0, 64'd0, 64'd0,  64'h28, 4, 0);
      prog[9]  = mk(64'h28, 32'h0020F333, 0, 1, 6, 64'd0,                   0, 0, 64'd0, 64'd0,  64'h2C, 4, 0);
      prog[10] = mk(64'h2C, 32'h0020E3B3, 0, 1, 7, 64'd15,                  0, 0, 64'd0, 64'd0,  64'h30, 4, 0);
      prog[11] = mk(64'h30, 32'hFFF08413, 0, 1, 8, 64'd4,                   0, 0, 64'd0, 64'd0,  64'h34, 4, 0);
      prog[12] = mk(64'h34, 32'h00803483, 0, 1, 9, 64'd10,                  1, 0, 64'd8, 64'd0,  64'h38, 5, 0);
      prog[13] = mk(64'h38, 32'h00000000, 0, 0, 0, 64'd0,                   0, 0, 64'd0, 64'd0,  64'h38, 2, 1);

      for (int i = 0; i < 16; i++) dmem[i] = 64'd0;
      rst_n = 1'b0;
      bus.imem_ready = 1'b0; bus.imem_rdata = '0;
      bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;

      @(negedge clk);
      chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
      chk("rst_dmem_req", 64'(bus.dmem_req), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_data", wb_data, 64'd0);
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_pc", pc, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) run_vec($sformatf("v%0d", i), prog[i]);

      // halt is sticky and issues no fetches
      sticky = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (!halt || bus.imem_req) sticky = 1'b0;
      end
      chk("halt_sticky", 64'(sticky), 64'd1);

      rst_n = 1'b0;
      #1;
      chk("halt_rst_clear", 64'(halt), 64'd0);
      chk("halt_rst_pc", pc, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_fetch(ok);
      chk("resume_req", 64'(ok), 64'd1);
      chk("resume_addr", bus.imem_addr, 64'd0);

      // reset while a store is stalled in MEM
      run_vec("r0", mk(64'h00, 32'h00500093, 0, 1, 1, 64'd5, 0, 0, 64'd0, 64'd0, 64'h04, 4, 0));
      wait_fetch(ok);
      chk("r1_fetch_req", 64'(ok), 64'd1);
      chk("r1_imem_addr", bus.imem_addr, 64'h04);
      bus.imem_ready = 1'b1;
      bus.imem_rdata = 32'h00103423;
      @(negedge clk);
      bus.imem_ready = 1'b0;
      n = 0;
      while (!bus.dmem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("r1_dmem_req", 64'(bus.dmem_req), 64'd1);
      chk("r1_dmem_addr", bus.dmem_addr, 64'd8);
      chk("r1_dmem_wdata", bus.dmem_wdata, 64'd5);
      repeat (2) @(negedge clk);
      chk("r1_dmem_stall", 64'(bus.dmem_req), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("r1_abort_dmem", 64'(bus.dmem_req), 64'd0);
      chk("r1_abort_imem", 64'(bus.imem_req), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // x1 was 5 before reset; add x10,x1,x1 must see cleared registers
      run_vec("r2", mk(64'h00, 32'h00108533, 0, 1, 10, 64'd0, 0, 0, 64'd0, 64'd0, 64'h04, 4, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
